// File: rtl/fpga_robots_game_ps2_pkg.sv
// Shared PS/2 frame constants and receiver FSM state encoding for the robots game.
package fpga_robots_game_ps2_pkg;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   // Odd parity holds when data plus parity bit carry an odd number of ones.
   function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/fpga_robots_game_fifo.sv
// Generic first-word-fall-through FIFO: RAM array plus a registered head word,
// so the read data never depends combinationally on the ready input.
module fpga_robots_game_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             full_o,
   output logic [AW:0]      count_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i
);

   localparam int DEPTH = 1 << AW;
   localparam int CW    = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             push, pop;

   assign full_o     = (count_q == CW'(DEPTH));
   assign rd_valid_o = (count_q != '0);
   assign count_o    = count_q;
   assign rd_data_o  = head_q;

   assign pop  = rd_valid_o && rd_ready_i;
   assign push = wr_en_i && (!full_o || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      // The head follows the new read pointer; bypass when this cycle's write lands there.
      if (push && (wr_ptr_q == rd_ptr_d)) begin
         head_d = wr_data_i;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/fpga_robots_game_ps2rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframing with error
// reporting, byte FIFO toward the game logic, and clock inhibit when nearly full.
module fpga_robots_game_ps2rx
   import fpga_robots_game_ps2_pkg::*;
#(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 130000,
   parameter int FIFO_AW    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_drive_low,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       err_parity,
   output logic       err_frame,
   output logic       err_overflow
);

   localparam int FCW   = $clog2(FILTER_LEN + 1);
   localparam int TCW   = $clog2(TIMEOUT + 1);
   localparam int CW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;

   // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
   logic [1:0]           sync1_q, sync2_q;
   logic [FCW-1:0]       fcnt_q, fcnt_d;
   logic                 filt_q, filt_d;
   logic                 fall;
   logic                 dat_s;
   logic [TCW-1:0]       tmo_q, tmo_d;
   logic                 timeout_hit;
   ps2_state_e           state_q, state_d;
   logic [2:0]           bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 oerr_q, oerr_d;
   logic                 fifo_push;
   logic                 fifo_full;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_pop;

   assign dat_s       = sync2_q[1];
   assign timeout_hit = (tmo_q == TCW'(TIMEOUT));
   assign fifo_pop    = rd_valid && rd_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {ps2_dat_i, ps2_clk_i};
         sync2_q <= sync1_q;
      end
   end

   // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      fall   = 1'b0;
      if (sync2_q[0] != filt_q) begin
         if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fall   = filt_q;
         end else begin
            fcnt_d = fcnt_q + FCW'(1);
         end
      end
   end

   always_comb begin
      tmo_d = tmo_q;
      if ((state_q == ST_IDLE) || fall) begin
         tmo_d = '0;
      end else if (!timeout_hit) begin
         tmo_d = tmo_q + TCW'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      oerr_d    = 1'b0;
      fifo_push = 1'b0;
      if ((state_q != ST_IDLE) && timeout_hit) begin
         state_d = ST_IDLE;
         ferr_d  = 1'b1;
      end else if (fall) begin
         unique case (state_q)
            ST_IDLE: begin
               if (dat_s == START_BIT) begin
                  state_d  = ST_DATA;
                  bitcnt_d = '0;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            ST_DATA: begin
               shift_d  = {dat_s, shift_q[DATA_BITS-1:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'(DATA_BITS - 1)) begin
                  state_d = ST_PARITY;
               end
            end
            ST_PARITY: begin
               par_d   = dat_s;
               state_d = ST_STOP;
            end
            ST_STOP: begin
               state_d = ST_IDLE;
               if (dat_s != STOP_BIT) begin
                  ferr_d = 1'b1;
               end else if (!odd_parity_ok(shift_q, par_q)) begin
                  perr_d = 1'b1;
               end else if (fifo_full && !fifo_pop) begin
                  oerr_d = 1'b1;
               end else begin
                  fifo_push = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         filt_q   <= 1'b1;
         fcnt_q   <= '0;
         tmo_q    <= '0;
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         oerr_q   <= 1'b0;
      end else begin
         filt_q   <= filt_d;
         fcnt_q   <= fcnt_d;
         tmo_q    <= tmo_d;
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         oerr_q   <= oerr_d;
      end
   end

   assign err_parity   = perr_q;
   assign err_frame    = ferr_q;
   assign err_overflow = oerr_q;

   // Only inhibit between frames, leaving room for the byte already in flight.
   assign ps2_clk_drive_low = (state_q == ST_IDLE) && (fifo_count >= CW'(DEPTH - 1));

   fpga_robots_game_fifo #(
      .WIDTH (DATA_BITS),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (fifo_push),
      .wr_data_i  (shift_q),
      .full_o     (fifo_full),
      .count_o    (fifo_count),
      .rd_data_o  (rd_data),
      .rd_valid_o (rd_valid),
      .rd_ready_i (rd_ready)
   );

endmodule

// File: tb/tb_fpga_robots_game_ps2rx.sv
// Directed bench for the PS/2 receiver: bit-banged frames on the pins, with a
// negedge monitor tallying pops, valid cycles and error pulses.
module tb_fpga_robots_game_ps2rx;

   localparam int H = 20;   // PS/2 half-period in system clocks

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       rd_ready = 1'b0;
   logic       drive_low;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       err_parity, err_frame, err_overflow;

   int checks = 0;
   int errors = 0;
   int n_valid = 0, n_perr = 0, n_ferr = 0, n_oerr = 0;
   logic [7:0] rx_q [$];

   always #5 clk = ~clk;

   fpga_robots_game_ps2rx #(
      .FILTER_LEN (8),
      .TIMEOUT    (300),
      .FIFO_AW    (3)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .ps2_clk_i         (ps2_clk),
      .ps2_dat_i         (ps2_dat),
      .ps2_clk_drive_low (drive_low),
      .rd_data           (rd_data),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .err_parity        (err_parity),
      .err_frame         (err_frame),
      .err_overflow      (err_overflow)
   );

   always @(negedge clk) begin
      if (rst) begin
         if (rd_valid && rd_ready) rx_q.push_back(rd_data);
         if (rd_valid) n_valid++;
         if (err_parity) n_perr++;
         if (err_frame) n_ferr++;
         if (err_overflow) n_oerr++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic par_of(input logic [7:0] d);
      return ~(^d);
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = frame[i];
         if (glitch) begin
            tick(12); ps2_clk = 1'b0; tick(4); ps2_clk = 1'b1; tick(4);
         end else tick(H);
         ps2_clk = 1'b0;
         if (glitch) begin
            tick(12); ps2_clk = 1'b1; tick(4); ps2_clk = 1'b0; tick(4);
         end else tick(H);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic par, input logic stop);
      send_bits({stop, par, d, 1'b0}, 11, 1'b0);
      tick(2 * H);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(3);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
      checks++; if (err_parity !== 1'b0) begin errors++; $display("FAIL reset_err_parity: got %b want 0", err_parity); end
      checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL reset_err_frame: got %b want 0", err_frame); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err_overflow: got %b want 0", err_overflow); end
      checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL reset_drive_low: got %b want 0", drive_low); end
      rst = 1'b1;
      tick(3);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rd_valid: got %b want 0", rd_valid); end
      $display("reset: done");
   endtask

   task automatic test_good_byte();
      int v0, e0;
      v0 = n_valid; e0 = n_perr + n_ferr + n_oerr;
      rd_ready = 1'b1; rx_q.delete();
      send_byte(8'h1C, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL good_count: got %0d bytes want 1", rx_q.size()); end
      checks++; if (rx_q.size() < 1 || rx_q[0] !== 8'h1C) begin errors++; $display("FAIL good_data: got %h want 1c", rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL good_valid_cycles: got %0d want 1", n_valid - v0); end
      checks++; if (n_perr + n_ferr + n_oerr - e0 != 0) begin errors++; $display("FAIL good_no_errors: got %0d pulses want 0", n_perr + n_ferr + n_oerr - e0); end
      $display("good byte 0x1C: received %0d byte(s)", rx_q.size());
   endtask

   task automatic test_parity_error();
      int p0, v0;
      p0 = n_perr; v0 = n_valid;
      rd_ready = 1'b1; rx_q.delete();
      send_byte(8'hF0, 1'b0, 1'b1);
      checks++; if (n_perr - p0 != 1) begin errors++; $display("FAIL parity_pulse: got %0d cycles want 1", n_perr - p0); end
      checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL parity_valid: got %0d cycles want 0", n_valid - v0); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL parity_no_push: got %0d bytes want 0", rx_q.size()); end
      $display("parity error 0xF0: err_parity cycles %0d", n_perr - p0);
   endtask

   task automatic test_frame_errors();
      int f0, p0;
      f0 = n_ferr; p0 = n_perr;
      rd_ready = 1'b1; rx_q.delete();
      send_byte(8'h5A, 1'b1, 1'b0);
      checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL stop_bit_pulse: got %0d cycles want 1", n_ferr - f0); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL stop_bit_no_push: got %0d bytes want 0", rx_q.size()); end
      send_bits(11'h7FF, 1, 1'b0);
      tick(2 * H);
      checks++; if (n_ferr - f0 != 2) begin errors++; $display("FAIL bad_start_pulse: got %0d cycles want 2", n_ferr - f0); end
      send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4, 1'b0);
      tick(500);
      checks++; if (n_ferr - f0 != 3) begin errors++; $display("FAIL timeout_pulse: got %0d cycles want 3", n_ferr - f0); end
      send_byte(8'h29, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h29) begin errors++; $display("FAIL after_timeout_data: got %0d bytes, first %h want 29", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (n_perr - p0 != 0 || n_ferr - f0 != 3) begin errors++; $display("FAIL after_timeout_errors: got perr %0d ferr %0d want 0 3", n_perr - p0, n_ferr - f0); end
      $display("frame errors: err_frame cycles %0d, then 0x29 received", n_ferr - f0);
   endtask

   task automatic test_fifo_inhibit();
      int o0;
      o0 = n_oerr;
      rd_ready = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         send_byte(8'(k), par_of(8'(k)), 1'b1);
         if (k == 6) begin
            checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL inhibit_after_6: got %b want 0", drive_low); end
         end
         if (k == 7) begin
            checks++; if (drive_low !== 1'b1) begin errors++; $display("FAIL inhibit_after_7: got %b want 1", drive_low); end
         end
      end
      checks++; if (n_oerr - o0 != 1) begin errors++; $display("FAIL overflow_pulse: got %0d cycles want 1", n_oerr - o0); end
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h01) begin errors++; $display("FAIL full_head: got valid %b data %h want 1 01", rd_valid, rd_data); end
      for (int k = 1; k <= 8; k++) begin
         checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(k)) begin errors++; $display("FAIL drain_%0d: got valid %b data %h want 1 %h", k, rd_valid, rd_data, 8'(k)); end
         rd_ready = 1'b1;
         tick(1);
         rd_ready = 1'b0;
         if (k == 1) begin
            checks++; if (drive_low !== 1'b1) begin errors++; $display("FAIL inhibit_count7: got %b want 1", drive_low); end
         end
         if (k == 2) begin
            checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL inhibit_release: got %b want 0", drive_low); end
         end
      end
      tick(1);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drained_empty: got %b want 0", rd_valid); end
      $display("fifo fill 0x01..0x09 and drain: overflow cycles %0d", n_oerr - o0);
   endtask

   task automatic test_glitch();
      int e0;
      e0 = n_perr + n_ferr + n_oerr;
      rd_ready = 1'b1; rx_q.delete();
      send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b1);
      tick(2 * H);
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL glitch_data: got %0d bytes, first %h want a5", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (n_perr + n_ferr + n_oerr - e0 != 0) begin errors++; $display("FAIL glitch_errors: got %0d pulses want 0", n_perr + n_ferr + n_oerr - e0); end
      $display("glitched frame 0xA5: received %0d byte(s)", rx_q.size());
   endtask

   task automatic test_reset_midframe();
      int e0;
      rd_ready = 1'b0;
      send_byte(8'h11, 1'b1, 1'b1);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin errors++; $display("FAIL prereset_head: got valid %b data %h want 1 11", rd_valid, rd_data); end
      send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 5, 1'b0);
      rst = 1'b0;
      tick(2);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midreset_rd_valid: got %b want 0", rd_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_rd_data: got %h want 00", rd_data); end
      checks++; if ({err_parity, err_frame, err_overflow} !== 3'b000) begin errors++; $display("FAIL midreset_errs: got %b want 000", {err_parity, err_frame, err_overflow}); end
      checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL midreset_drive_low: got %b want 0", drive_low); end
      rst = 1'b1;
      tick(2);
      e0 = n_perr + n_ferr + n_oerr;
      rd_ready = 1'b1; rx_q.delete();
      send_byte(8'h76, 1'b0, 1'b1);
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h76) begin errors++; $display("FAIL postreset_data: got %0d bytes, first %h want 76", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); end
      checks++; if (n_perr + n_ferr + n_oerr - e0 != 0) begin errors++; $display("FAIL postreset_errors: got %0d pulses want 0", n_perr + n_ferr + n_oerr - e0); end
      $display("reset mid-frame then 0x76: received %0d byte(s)", rx_q.size());
   endtask

   initial begin
      test_reset();
      test_good_byte();
      test_parity_error();
      test_frame_errors();
      test_fifo_inhibit();
      test_glitch();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fpga_robots_game_ps2rx.md
# fpga_robots_game_ps2rx

PS/2 keyboard receiver for the robots game. It sits directly downstream of the top-level `ps2a_clk`/`ps2a_dat` pins and upstream of the game-play logic. It synchronizes and filters the device clock and data lines, and deframes the 11-bit PS/2 frames. Checked bytes are delivered through a small first-word-fall-through FIFO with a valid/ready handshake. It inhibits the keyboard by holding the PS/2 clock low when the FIFO cannot accept more bytes.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before the filtered PS/2 clock changes.
- `TIMEOUT`, 130000: system clocks (2 ms at 65 MHz) allowed between falling edges inside one frame.
- `FIFO_AW`, 3: FIFO address width; depth is 2^FIFO_AW = 8 bytes.
- `clk` in 1: system clock, ~65 MHz, the video pixel clock.
- `rst` in 1: asynchronous, active-low reset.
- `ps2_clk_i` in 1: raw PS/2 clock pin input.
- `ps2_dat_i` in 1: raw PS/2 data pin input.
- `ps2_clk_drive_low` out 1: 1 means the top level drives `ps2a_clk` to 0; 0 means the pin is high-Z.
- `rd_data` out 8: byte at the FIFO head.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: consumer accepts `rd_data` this cycle.
- `err_parity` out 1: one-cycle pulse on a parity failure.
- `err_frame` out 1: one-cycle pulse on a bad start bit, bad stop bit, or timeout.
- `err_overflow` out 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input conditioning.**
  - Both pins pass through a 2-flop synchronizer.
  - The clock then passes through a saturating filter counter: the filtered clock flips only after `FILTER_LEN` consecutive samples differ from its current value.
  - A falling edge of the filtered clock samples the synchronized data bit in the same cycle.
- **FSM states.**
  - IDLE: an edge with data 0 goes to DATA and clears `bitcnt`. An edge with data 1 pulses `err_frame` and stays in IDLE.
  - DATA: shifts data in LSB first. After the 8th bit (`bitcnt`==7) it goes to PARITY.
  - PARITY: stores the bit and goes to STOP.
  - STOP: handles the stop bit, then returns to IDLE in every case.
    - Stop bit 0: pulse `err_frame`.
    - Otherwise, if the odd parity of data+parity bit fails: pulse `err_parity`.
    - Otherwise, if the FIFO is full and there is no pop this cycle: pulse `err_overflow`.
    - Otherwise: push the byte.
- **Timeout.**
  - The timeout counter clears on every filtered falling edge and when in IDLE, and saturates at `TIMEOUT`.
  - Reaching `TIMEOUT` outside IDLE pulses `err_frame`, discards the partial frame and returns to IDLE.
- **FIFO.**
  - Holds 2^FIFO_AW entries and keeps a count of FIFO_AW+1 bits.
  - A pop occurs when `rd_valid` && `rd_ready`.
  - Push and pop in the same cycle on a full FIFO are both accepted; the count is unchanged.
  - Pointers wrap modulo the depth.
  - `rd_ready` while empty has no effect.
- **Inhibit.**
  - `ps2_clk_drive_low` is 1 when the state is IDLE and the FIFO count is ≥ depth−1.
  - Inhibit never asserts mid-frame.
  - Inhibit releases on the cycle after the count drops below depth−1.
- **Reset (`rst` low).**
  - Values: state IDLE, FIFO empty, `rd_valid`=0, `rd_data`=0, all error outputs 0, `ps2_clk_drive_low`=0.
  - Synchronizers and the filter are set to 1 (idle bus level).
  - A frame in progress when reset asserts is discarded.

## Timing
- Pin-to-filtered-edge latency: 2 + `FILTER_LEN` clocks.
- The stop-bit edge is processed in cycle N. The FIFO write and the error pulses register at the end of N. `rd_valid` and `rd_data` are valid in cycle N+1.
- `rd_data` is stable while `rd_valid`=1 and `rd_ready`=0.
- After a pop, the next entry appears in the following cycle.
- Error pulses last exactly 1 cycle. They register at the same time as the FIFO write would.
- The FIFO is a registered RAM with a head register, so there is no combinational path from `rd_ready` to `rd_data`.

## Structure
- Frame constants (start=0, stop=1, 8 data bits, odd parity) belong in a shared `fpga_robots_game_ps2_pkg` include. That include also holds the FSM state encodings (2 bits).
- One sub-module is natural: `fpga_robots_game_fifo`, a generic FWFT FIFO parameterized by width and address width. It is reused later for the serial port.
- Synchronizer, filter and FSM stay in this module.

## Test plan
- Frame 0x1C with parity bit 0, clock period 80 µs, `rd_ready`=1 → `rd_data`=0x1C, `rd_valid` for 1 cycle, no errors.
- Frame 0xF0 with parity bit 0 (wrong; correct is 1) → `err_parity` pulse, `rd_valid` stays 0.
- Frame 0x5A with stop bit 0 → `err_frame` pulse, no push. Then a 2 ms gap after 4 bits of a new frame → `err_frame` pulse, state IDLE. The next valid frame 0x29 is received correctly.
- `rd_ready`=0, send bytes 0x01..0x09:
  - `ps2_clk_drive_low` goes to 1 after the 7th byte.
  - The bench ignores the inhibit to send the 8th and 9th bytes: the 8th is stored and the 9th pulses `err_overflow`.
  - Reading then yields 0x01..0x08 in order.
- 4-cycle glitches on `ps2_clk_i` during a frame → ignored, byte correct.
- `rst` low mid-frame after 5 bits, then a full frame 0x76 → only 0x76 delivered, and all outputs were 0 during reset.
